writeback_pc_unit: RTL and testbench

WRITEBACK_PC_UNIT -- requirements
Module: writeback_pc_unit

---
 rtl/writeback_pc_unit.sv | 204 ++++++++++++++++++++
 tb/tb_writeback_pc_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_pc_unit.sv
// Writeback and PC-update stage.
// Selects the next PC (register jump, index jump, taken branch or fall-through)
// and the writeback word (UART, memory, link or ALU), then registers both with
// one cycle of latency. A UART load with no word available stalls the stage; a
// two-state RUN/WAIT machine counts the cycles spent waiting for that word.
// Retired instructions are counted.
module writeback_pc_unit #(
  parameter int                        INST_MEM_WIDTH = 2,
  parameter logic [INST_MEM_WIDTH-1:0] RESET_PC       = '0,
  parameter int                        RETIRE_WIDTH   = 32,
  parameter int                        WAIT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      RegWrite,
  input  logic                      MemtoReg,
  input  logic                      UARTtoReg,
  input  logic                      Branch,
  input  logic                      Link,
  input  logic [1:0]                JumpMode,
  input  logic [31:0]               read_data,
  input  logic [31:0]               register_data,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               input_data,
  input  logic [4:0]                rd,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  input  logic                      input_valid,
  output logic                      input_ready,
  output logic                      RegWrite_next,
  output logic [4:0]                rd_next,
  output logic [31:0]               data,
  output logic [INST_MEM_WIDTH-1:0] pc,
  output logic                      stall,
  output logic [RETIRE_WIDTH-1:0]   retire_count,
  output logic [WAIT_WIDTH-1:0]     wait_cycles
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;

  logic                      need_in_s;
  logic                      stall_raw_s;
  logic                      retire_s;
  logic [INST_MEM_WIDTH-1:0] pc_next_s;
  logic [31:0]               wb_data_s;

  logic [INST_MEM_WIDTH-1:0] pc_r;
  logic [31:0]               data_r;
  logic [4:0]                rd_next_r;
  logic                      reg_write_next_r;
  logic [RETIRE_WIDTH-1:0]   retire_count_r;
  logic [WAIT_WIDTH-1:0]     wait_cycles_r;

  // Zero-extended views so any PC width can be cut from the low bits safely.
  logic [INST_MEM_WIDTH+31:0] reg_data_ext_s;
  logic [INST_MEM_WIDTH+25:0] inst_index_ext_s;
  logic [INST_MEM_WIDTH+31:0] link_ext_s;

  assign reg_data_ext_s   = {{INST_MEM_WIDTH{1'b0}}, register_data};
  assign inst_index_ext_s = {{INST_MEM_WIDTH{1'b0}}, inst_index};
  assign link_ext_s       = {{32{1'b0}}, pc1};

  // A UART load without a word in hand freezes the stage; otherwise it retires.
  assign need_in_s   = valid_in & UARTtoReg;
  assign stall_raw_s = need_in_s & ~input_valid;
  assign retire_s    = valid_in & ~stall_raw_s;

  // Combinational handshakes are held quiet while reset is asserted.
  assign stall       = reset & stall_raw_s;
  assign input_ready = reset & need_in_s & input_valid;

  assign pc            = pc_r;
  assign data          = data_r;
  assign rd_next       = rd_next_r;
  assign RegWrite_next = reg_write_next_r;
  assign retire_count  = retire_count_r;
  assign wait_cycles   = wait_cycles_r;

  // Next-PC select: register jump, then index jump, then taken branch, else pc+1.
  always_comb begin
    pc_next_s = pc1;
    case (JumpMode)
      2'b10: pc_next_s = reg_data_ext_s[INST_MEM_WIDTH-1:0];
      2'b01: pc_next_s = inst_index_ext_s[INST_MEM_WIDTH-1:0];
      default: begin
        if (Branch && (alu_result != 32'd0)) begin
          pc_next_s = pc2;
        end else begin
          pc_next_s = pc1;
        end
      end
    endcase
  end

  // Writeback source select: UART beats memory beats link beats ALU.
  always_comb begin
    wb_data_s = alu_result;
    if (UARTtoReg) begin
      wb_data_s = input_data;
    end else if (MemtoReg) begin
      wb_data_s = read_data;
    end else if (Link) begin
      wb_data_s = link_ext_s[31:0];
    end else begin
      wb_data_s = alu_result;
    end
  end

  // RUN/WAIT next state: enter WAIT on a stall, leave when the word arrives or the instruction goes away.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (stall_raw_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (input_valid || !valid_in) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC register: advances only when an instruction retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (retire_s) begin
      pc_r <= pc_next_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Writeback register: write enable is a one-cycle pulse, never to r0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r           <= 32'd0;
      rd_next_r        <= 5'd0;
      reg_write_next_r <= 1'b0;
    end else if (retire_s) begin
      data_r           <= wb_data_s;
      rd_next_r        <= rd;
      reg_write_next_r <= RegWrite & (rd != 5'd0);
    end else begin
      data_r           <= data_r;
      rd_next_r        <= rd_next_r;
      reg_write_next_r <= 1'b0;
    end
  end

  // Retire counter, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count_r <= {RETIRE_WIDTH{1'b0}};
    end else if (retire_s) begin
      retire_count_r <= retire_count_r + RETIRE_WIDTH'(1);
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  // Wait counter: cleared on WAIT entry, saturating count of idle WAIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cycles_r <= {WAIT_WIDTH{1'b0}};
    end else if (state_r == ST_RUN) begin
      if (state_next_s == ST_WAIT) begin
        wait_cycles_r <= {WAIT_WIDTH{1'b0}};
      end else begin
        wait_cycles_r <= wait_cycles_r;
      end
    end else if (!input_valid && (wait_cycles_r != {WAIT_WIDTH{1'b1}})) begin
      wait_cycles_r <= wait_cycles_r + WAIT_WIDTH'(1);
    end else begin
      wait_cycles_r <= wait_cycles_r;
    end
  end

endmodule

// File: tb/tb_writeback_pc_unit.sv
// Bench for writeback_pc_unit: directed scenarios plus randomized traffic.
// A reference model predicts the registered outputs of every cycle and queues
// them; a monitor pops one prediction per rising edge and compares.
module tb_writeback_pc_unit;

  localparam int             IW  = 2;
  localparam int             RW  = 32;
  localparam int             WW  = 3;
  localparam logic [IW-1:0]  RPC = 2'd3;

  logic          clk;
  logic          reset;
  logic          valid_in, RegWrite, MemtoReg, UARTtoReg, Branch, Link;
  logic [1:0]    JumpMode;
  logic [31:0]   read_data, register_data, alu_result, input_data;
  logic [4:0]    rd;
  logic [25:0]   inst_index;
  logic [IW-1:0] pc1, pc2;
  logic          input_valid;
  logic          input_ready;
  logic          RegWrite_next;
  logic [4:0]    rd_next;
  logic [31:0]   data;
  logic [IW-1:0] pc;
  logic          stall;
  logic [RW-1:0] retire_count;
  logic [WW-1:0] wait_cycles;

  writeback_pc_unit #(
    .INST_MEM_WIDTH(IW), .RESET_PC(RPC), .RETIRE_WIDTH(RW), .WAIT_WIDTH(WW)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .UARTtoReg(UARTtoReg), .Branch(Branch), .Link(Link),
    .JumpMode(JumpMode), .read_data(read_data), .register_data(register_data),
    .alu_result(alu_result), .input_data(input_data), .rd(rd),
    .inst_index(inst_index), .pc1(pc1), .pc2(pc2), .input_valid(input_valid),
    .input_ready(input_ready), .RegWrite_next(RegWrite_next), .rd_next(rd_next),
    .data(data), .pc(pc), .stall(stall), .retire_count(retire_count),
    .wait_cycles(wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rw;
    logic [4:0]    rd;
    logic [31:0]   data;
    logic [IW-1:0] pc;
    logic [RW-1:0] rc;
    logic [WW-1:0] wc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic          m_rw;
  logic [4:0]    m_rd;
  logic [31:0]   m_data;
  logic [IW-1:0] m_pc;
  logic [RW-1:0] m_rc;
  int            m_wc;
  bit            m_waiting;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_outputs(input exp_t e, input string tag);
    chk({tag, "_RegWrite_next"}, RegWrite_next, e.rw);
    chk({tag, "_rd_next"}, rd_next, e.rd);
    chk({tag, "_data"}, data, e.data);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_retire_count"}, retire_count, e.rc);
    chk({tag, "_wait_cycles"}, wait_cycles, e.wc);
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.rw = m_rw; e.rd = m_rd; e.data = m_data; e.pc = m_pc; e.rc = m_rc;
    e.wc = WW'(m_wc);
    return e;
  endfunction

  task automatic model_reset();
    m_rw = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_pc = RPC; m_rc = '0;
    m_wc = 0; m_waiting = 1'b0;
  endtask

  // One cycle: called at a falling edge with inputs already applied.
  task automatic tick();
    bit need, stl, rdy, ret;
    int max_wc;
    #1;
    if (!reset) begin
      model_reset();
      chk("rst_stall", stall, 1'b0);
      chk("rst_input_ready", input_ready, 1'b0);
      cmp_outputs(model_snapshot(), "async_rst");
    end else begin
      max_wc = (1 << WW) - 1;
      need = valid_in && UARTtoReg;
      stl  = need && !input_valid;
      rdy  = need && input_valid;
      ret  = valid_in && !stl;
      chk("stall", stall, stl);
      chk("input_ready", input_ready, rdy);
      if (!m_waiting) begin
        if (stl) begin
          m_waiting = 1'b1;
          m_wc = 0;
        end
      end else begin
        if (!input_valid && m_wc < max_wc) m_wc = m_wc + 1;
        if (input_valid || !valid_in) m_waiting = 1'b0;
      end
      if (ret) begin
        if (JumpMode == 2'b10)      m_pc = IW'(register_data % (1 << IW));
        else if (JumpMode == 2'b01) m_pc = IW'(inst_index % (1 << IW));
        else if (Branch && alu_result != 0) m_pc = pc2;
        else m_pc = pc1;
        if (UARTtoReg)     m_data = input_data;
        else if (MemtoReg) m_data = read_data;
        else if (Link)     m_data = 32'(pc1);
        else               m_data = alu_result;
        m_rd = rd;
        m_rw = RegWrite && (rd != 0);
        m_rc = m_rc + 1;
      end else begin
        m_rw = 1'b0;
      end
    end
    q.push_back(model_snapshot());
    @(negedge clk);
  endtask

  task automatic set_idle();
    valid_in = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; UARTtoReg = 1'b0;
    Branch = 1'b0; Link = 1'b0; JumpMode = 2'b00; read_data = 32'd0;
    register_data = 32'd0; alu_result = 32'd0; input_data = 32'd0; rd = 5'd0;
    inst_index = 26'd0; pc1 = '0; pc2 = '0; input_valid = 1'b0;
  endtask

  // Monitor: one prediction per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp_outputs(e, "mon");
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    tick();
    reset = 1'b1;
    tick();

    // ALU op writing r3
    valid_in = 1'b1; RegWrite = 1'b1; rd = 5'd3; alu_result = 32'h2A; pc1 = 2'd1;
    tick();
    chk("alu_RegWrite_next", RegWrite_next, 1'b1);
    chk("alu_rd_next", rd_next, 5'd3);
    chk("alu_data", data, 32'h2A);
    chk("alu_pc", pc, 2'd1);
    chk("alu_retire_count", retire_count, 32'd1);

    // Taken then not-taken branch
    set_idle();
    valid_in = 1'b1; Branch = 1'b1; alu_result = 32'd1; pc2 = 2'd2; pc1 = 2'd3;
    tick();
    chk("br_taken_pc", pc, 2'd2);
    alu_result = 32'd0;
    tick();
    chk("br_not_taken_pc", pc, 2'd3);

    // UART load waiting five cycles
    set_idle();
    valid_in = 1'b1; UARTtoReg = 1'b1; RegWrite = 1'b1; rd = 5'd7; pc1 = 2'd1;
    input_data = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("uart_pc_frozen", pc, 2'd3);
    input_valid = 1'b1;
    tick();
    chk("uart_wait_cycles", wait_cycles, 3'd4);
    chk("uart_data", data, 32'hDEAD);
    chk("uart_pc", pc, 2'd1);

    // r0 write suppressed, register jump truncated to PC width
    set_idle();
    valid_in = 1'b1; RegWrite = 1'b1; rd = 5'd0; JumpMode = 2'b10;
    register_data = 32'hFFFF_FFFE; pc1 = 2'd0;
    tick();
    chk("r0_RegWrite_next", RegWrite_next, 1'b0);
    chk("jr_pc", pc, 2'd2);

    // Index jump, then reserved jump mode falls through to pc1
    set_idle();
    valid_in = 1'b1; JumpMode = 2'b01; inst_index = 26'h3FF_FFFD; pc1 = 2'd0;
    tick();
    chk("j_pc", pc, 2'd1);
    JumpMode = 2'b11; pc1 = 2'd3; Branch = 1'b1; alu_result = 32'd0; pc2 = 2'd2;
    tick();
    chk("jm11_pc", pc, 2'd3);

    // Long wait saturates the wait counter
    set_idle();
    valid_in = 1'b1; UARTtoReg = 1'b1; input_data = 32'h1234_5678; pc1 = 2'd2;
    for (int i = 0; i < 11; i++) begin
      tick();
    end
    input_valid = 1'b1;
    tick();
    chk("sat_wait_cycles", wait_cycles, 3'd7);

    // WAIT left because the instruction is withdrawn
    set_idle();
    valid_in = 1'b1; UARTtoReg = 1'b1;
    tick();
    tick();
    valid_in = 1'b0;
    tick();

    // Reset asserted during WAIT, word offered at the same moment
    set_idle();
    valid_in = 1'b1; UARTtoReg = 1'b1; RegWrite = 1'b1; rd = 5'd9;
    input_data = 32'hCAFE_F00D; pc1 = 2'd1;
    tick();
    tick();
    tick();
    reset = 1'b0; input_valid = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_data", data, 32'hCAFE_F00D);
    chk("post_rst_retire_count", retire_count, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      valid_in      = ($urandom_range(0, 3) != 0);
      UARTtoReg     = ($urandom_range(0, 3) == 0);
      input_valid   = ($urandom_range(0, 2) == 0);
      RegWrite      = $urandom_range(0, 1);
      MemtoReg      = $urandom_range(0, 1);
      Branch        = $urandom_range(0, 1);
      Link          = $urandom_range(0, 1);
      JumpMode      = 2'($urandom_range(0, 3));
      read_data     = $urandom;
      register_data = $urandom;
      alu_result    = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      input_data    = $urandom;
      rd            = 5'($urandom_range(0, 31));
      inst_index    = 26'($urandom);
      pc1           = IW'($urandom);
      pc2           = IW'($urandom);
      tick();
    end

    set_idle();
    tick();
    tick();
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
